// File: rtl/tt_row_mux_seq_if.sv
// Spine-side handshake bundle for tt_row_mux_seq.
// Select word, strobe, enable and data towards the row; mux output back.
interface tt_row_mux_seq_if #(
  parameter int U_OW  = 24,
  parameter int U_IW  = 18,
  parameter int SEL_W = 9
);
  logic [U_OW-1:0]  spine_ow;
  logic [U_IW-1:0]  si_usr;
  logic [SEL_W-1:0] si_sel;
  logic             si_stb;
  logic             si_ena;

  modport master (
    output si_usr, si_sel, si_stb, si_ena,
    input  spine_ow
  );

  modport slave (
    input  si_usr, si_sel, si_stb, si_ena,
    output spine_ow
  );
endinterface

// File: rtl/tt_row_mux_seq.sv
// Strobed row mux with guarded switch-over between user modules.
// Optional TT_ROW_MUX_OW_REG_EN registers the spine output path.
module tt_row_mux_seq #(
  parameter int G_X       = 16,
  parameter int G_Y       = 2,
  parameter int N_IO      = 8,
  parameter int N_O       = 8,
  parameter int N_I       = 10,
  parameter int ADDR_W    = 4,
  parameter int GUARD_CYC = 2,
  localparam int U_OW  = N_O + 2 * N_IO,
  localparam int U_IW  = N_I + N_IO,
  localparam int COL_W = $clog2(G_X),
  localparam int Y_W   = (G_Y > 1) ? $clog2(G_Y) : 1,
  localparam int SEL_W = ADDR_W + Y_W + COL_W,
  localparam int N_M   = G_X * G_Y
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [U_OW*N_M-1:0]  um_ow,
  output logic [U_IW*N_M-1:0]  um_iw,
  output logic [N_M-1:0]       um_ena,
  output logic [N_M-1:0]       um_k_zero,
  tt_row_mux_seq_if.slave      sp,
  input  logic [ADDR_W-1:0]    addr,
  output logic                 row_active,
  output logic                 k_zero,
  output logic                 k_one
);

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    ACTIVE
  } state_t;

  localparam logic [3:0] GC = 4'(GUARD_CYC);

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [COL_W-1:0] cur_x, x_nx;
  logic [Y_W-1:0]   cur_y, y_nx;

  logic [ADDR_W-1:0] sel_a;
  logic [Y_W-1:0]    sel_y;
  logic [COL_W-1:0]  sel_x;
  logic              match;
  logic              same;
  logic              load;
  int                idx;
  logic [U_OW-1:0]   ow_cur;

  assign sel_a = sp.si_sel[SEL_W-1 -: ADDR_W];
  assign sel_y = sp.si_sel[COL_W +: Y_W];
  assign sel_x = sp.si_sel[COL_W-1:0];
  assign match = (sel_a == addr) && (int'(sel_y) < G_Y);
  assign same  = (sel_x == cur_x) && (sel_y == cur_y);

  assign idx    = int'(cur_y) * G_X + int'(cur_x);
  assign ow_cur = um_ow[U_OW*idx +: U_OW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cur_x <= x_nx;
      cur_y <= y_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    x_nx     = cur_x;
    y_nx     = cur_y;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sp.si_stb && match) load = 1'b1;
      end
      GUARD: begin
        if (sp.si_stb) begin
          if (match) load = 1'b1;
          else       state_nx = IDLE;
        end else if (cnt <= 4'd1) begin
          state_nx = ACTIVE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ACTIVE: begin
        if (sp.si_stb) begin
          if (!match)     state_nx = IDLE;
          else if (!same) load = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (load) begin
      x_nx     = sel_x;
      y_nx     = sel_y;
      cnt_nx   = GC;
      state_nx = (GC == 4'd0) ? ACTIVE : GUARD;
    end
  end

  always_comb begin
    um_ena = '0;
    um_iw  = '0;
    if (state == ACTIVE) begin
      um_ena[idx] = sp.si_ena;
      if (sp.si_ena) um_iw[U_IW*idx +: U_IW] = sp.si_usr;
    end
  end

  assign row_active = (state == ACTIVE);
  assign um_k_zero  = '0;
  assign k_zero     = 1'b0;
  assign k_one      = 1'b1;

`ifdef TT_ROW_MUX_OW_REG_EN
  logic [U_OW-1:0] ow_q;
  logic            act_q;

  // act_q drops across any module change so a stale word never reaches the spine
  always_ff @(posedge clk) begin
    if (rst) begin
      ow_q  <= '0;
      act_q <= 1'b0;
    end else begin
      ow_q  <= ow_cur;
      act_q <= (state == ACTIVE) && (state_nx == ACTIVE) && !load;
    end
  end

  assign sp.spine_ow = (act_q && state == ACTIVE) ? ow_q : 'z;
`else
  assign sp.spine_ow = (state == ACTIVE) ? ow_cur : 'z;
`endif

endmodule

// File: tb/tb_tt_row_mux_seq.sv
// Directed self-checking bench for tt_row_mux_seq.
// Default build: addr 3, GUARD_CYC 2, G_X 16, G_Y 2.
module tb_tt_row_mux_seq;

  localparam int U_OW = 24;
  localparam int U_IW = 18;
  localparam int N_M  = 32;
  localparam int SEL_W = 9;

  logic clk = 1'b0;
  logic rst;
  logic [U_OW*N_M-1:0] um_ow;
  logic [U_IW*N_M-1:0] um_iw;
  logic [N_M-1:0]      um_ena;
  logic [N_M-1:0]      um_k_zero;
  logic [3:0]          addr;
  logic                row_active;
  logic                k_zero;
  logic                k_one;

  int n_tests = 0;
  int n_fail  = 0;

  tt_row_mux_seq_if #(.U_OW(U_OW), .U_IW(U_IW), .SEL_W(SEL_W)) sp_if ();

  tt_row_mux_seq dut (
    .clk        (clk),
    .rst        (rst),
    .um_ow      (um_ow),
    .um_iw      (um_iw),
    .um_ena     (um_ena),
    .um_k_zero  (um_k_zero),
    .sp         (sp_if),
    .addr       (addr),
    .row_active (row_active),
    .k_zero     (k_zero),
    .k_one      (k_one)
  );

  always #5 clk = ~clk;

  function automatic logic [U_OW-1:0] pat(int m);
    return 24'h5A0000 + 24'(m) * 24'h000101;
  endfunction

  function automatic logic [N_M-1:0] oh(int m);
    logic [N_M-1:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  function automatic logic [U_IW*N_M-1:0] iw_at(int m, logic [U_IW-1:0] d);
    logic [U_IW*N_M-1:0] v;
    v = '0;
    v[U_IW*m +: U_IW] = d;
    return v;
  endfunction

  task automatic chk(string tag, logic [639:0] obs, logic [639:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(logic [3:0] a, logic y, logic [3:0] x);
    sp_if.si_sel = {a, y, x};
    sp_if.si_stb = 1'b1;
    step();
    sp_if.si_stb = 1'b0;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_ena"}, 640'(um_ena), 640'(0));
    chk({tag, "_iw"}, 640'(um_iw), 640'(0));
    chk({tag, "_sp"}, 640'(sp_if.spine_ow), {616'd0, {U_OW{1'bz}}});
    chk({tag, "_act"}, 640'(row_active), 640'(0));
  endtask

  initial begin
    logic [U_OW-1:0] z24;
    z24 = 'z;
    for (int m = 0; m < N_M; m++) um_ow[U_OW*m +: U_OW] = pat(m);
    addr = 4'd3;
    rst = 1'b1;
    sp_if.si_usr = '0;
    sp_if.si_sel = '0;
    sp_if.si_stb = 1'b0;
    sp_if.si_ena = 1'b0;
    step();
    step();
    chk_idle("rst");
    chk("k_zero", 640'(k_zero), 640'(0));
    chk("k_one", 640'(k_one), 640'(1));
    chk("um_k_zero", 640'(um_k_zero), 640'(0));
    rst = 1'b0;
    step();
    chk_idle("idle");

    // select {3,1,5} -> module 21 after two guard cycles
    sp_if.si_ena = 1'b1;
    sp_if.si_usr = 18'h2A5;
    strobe(4'd3, 1'b1, 4'd5);
    chk_idle("g1a");
    step();
    chk_idle("g1b");
    step();
    chk("a21_ena", 640'(um_ena), 640'(oh(21)));
    chk("a21_iw", 640'(um_iw), 640'(iw_at(21, 18'h2A5)));
    chk("a21_act", 640'(row_active), 640'(1));
`ifdef TT_ROW_MUX_OW_REG_EN
    chk("a21_sp0", 640'(sp_if.spine_ow), {616'd0, z24});
`else
    chk("a21_sp0", 640'(sp_if.spine_ow), 640'(pat(21)));
`endif
    sp_if.si_ena = 1'b0;
    #1;
    chk("a21_ena0", 640'(um_ena), 640'(0));
    chk("a21_iw0", 640'(um_iw), 640'(0));
    step();
    chk("a21_sp1", 640'(sp_if.spine_ow), 640'(pat(21)));
    sp_if.si_ena = 1'b1;
    #1;

    // switch to {3,0,2}: two enable-low cycles then module 2
    sp_if.si_usr = 18'h1F0F;
    strobe(4'd3, 1'b0, 4'd2);
    chk_idle("sw_a");
    step();
    chk_idle("sw_b");
    step();
    chk("a2_ena", 640'(um_ena), 640'(oh(2)));
    chk("a2_iw", 640'(um_iw), 640'(iw_at(2, 18'h1F0F)));
    step();
    chk("a2_sp", 640'(sp_if.spine_ow), 640'(pat(2)));

    // foreign address deselects, and further foreign strobes stay idle
    strobe(4'd4, 1'b0, 4'd0);
    chk_idle("desel");
    strobe(4'd4, 1'b1, 4'd3);
    chk_idle("desel2");
    step();
    step();
    chk_idle("desel3");

    // re-strobe inside guard restarts the counter
    strobe(4'd3, 1'b1, 4'd5);
    chk_idle("rg_a");
    strobe(4'd3, 1'b0, 4'd7);
    chk_idle("rg_b");
    step();
    chk_idle("rg_c");
    step();
    chk("a7_ena", 640'(um_ena), 640'(oh(7)));

    // held identical strobe is idempotent in ACTIVE
    sp_if.si_sel = {4'd3, 1'b0, 4'd7};
    sp_if.si_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d", i), 640'(um_ena), 640'(oh(7)));
    end
    sp_if.si_stb = 1'b0;
    step();
    chk("hold_sp", 640'(sp_if.spine_ow), 640'(pat(7)));

    // synchronous reset from ACTIVE
    rst = 1'b1;
    #1;
    chk("prerst_ena", 640'(um_ena), 640'(oh(7)));
    step();
    chk_idle("rst2");
    rst = 1'b0;
    step();
    chk_idle("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
